// File: rtl/dac_sample_feeder.sv
// dac_sample_feeder
//
// Paces 16-bit audio samples into the SPI DAC serializer at a fixed sample
// rate. Samples enter a small FIFO through a valid/ready handshake. A free-running
// divider on CLK_50 produces one sample tick every DIV cycles. Each tick pops one
// sample onto DATA16 and starts a LOAD_W-cycle LOAD pulse. If a tick finds the
// FIFO empty, DATA16 holds its previous value and an underrun is flagged. The LOAD
// pulse is still issued, so the DAC frame rate stays constant.
//
// Parameters
//   DIV        : CLK_50 cycles per sample tick (640..65535)
//   DEPTH_LOG2 : FIFO depth is 2**DEPTH_LOG2 entries (1..8)
//   LOAD_W     : LOAD pulse width in CLK_50 cycles (>= 2)
//
// Ports
//   CLK_50       in   system clock, rising edge
//   RESET_N      in   synchronous active-low reset
//   S_DATA       in   [15:0] upstream sample
//   S_VALID      in   S_DATA valid
//   S_READY      out  FIFO can accept a sample (registered)
//   DATA16       out  [15:0] sample presented to the serializer
//   LOAD         out  frame-start request, LOAD_W cycles wide
//   UNDERRUN     out  one-cycle pulse when a tick finds the FIFO empty
//   UNDERRUN_CNT out  [15:0] saturating underrun count
//   FILL         out  [DEPTH_LOG2:0] FIFO occupancy (registered)
//
// Build option
//   DAC_FEED_SIGNED_EN : when defined, S_DATA is two's complement. It is
//                        converted to offset binary by inverting bit 15.

module dac_sample_feeder #(
    parameter int DIV        = 1250,
    parameter int DEPTH_LOG2 = 4,
    parameter int LOAD_W     = 4
) (
    input  logic                  CLK_50,
    input  logic                  RESET_N,
    input  logic [15:0]           S_DATA,
    input  logic                  S_VALID,
    output logic                  S_READY,
    output logic [15:0]           DATA16,
    output logic                  LOAD,
    output logic                  UNDERRUN,
    output logic [15:0]           UNDERRUN_CNT,
    output logic [DEPTH_LOG2:0]   FILL
);

    localparam int                  DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [15:0]         TICK_AT    = 16'(DIV - 1);
    localparam logic [15:0]         MIDSCALE   = 16'h8000;
    localparam int                  WCNT_W     = (LOAD_W > 2) ? $clog2(LOAD_W) : 1;
    localparam logic [WCNT_W-1:0]   WIDTH_INIT = WCNT_W'(LOAD_W - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        PULSE = 1'b1
    } state_t;

    logic [15:0]           mem_reg [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr_reg;
    logic [DEPTH_LOG2-1:0] wr_ptr_reg;
    logic [DEPTH_LOG2:0]   fill_reg;
    logic [DEPTH_LOG2:0]   fill_next;
    logic                  s_ready_reg;
    logic [15:0]           div_cnt_reg;
    logic [15:0]           data16_reg;
    logic                  underrun_reg;
    logic [15:0]           underrun_cnt_reg;
    state_t                state_reg;
    logic [WCNT_W-1:0]     width_cnt_reg;
    logic                  load_reg;

    logic                  tick;
    logic                  push;
    logic                  pop;
    logic                  empty;
    logic [15:0]           head_word;
    logic [15:0]           head_conv;

    always_comb begin
        tick  = (div_cnt_reg == TICK_AT);
        empty = (fill_reg == '0);
        // S_READY is registered, so a full FIFO refuses a sample even when a pop
        // happens in the same cycle.
        push  = S_VALID && s_ready_reg;
        // There is no bypass path. A sample pushed on an empty-FIFO tick waits
        // for the next tick.
        pop   = tick && !empty;
        fill_next = fill_reg;
        case ({push, pop})
            2'b10:   fill_next = fill_reg + 1'b1;
            2'b01:   fill_next = fill_reg - 1'b1;
            default: fill_next = fill_reg;
        endcase
        head_word = mem_reg[rd_ptr_reg];
    end

    // Magnitude bits always pass straight through. Only the sign bit differs
    // between the two sample formats.
    genvar gi;
    generate
        for (gi = 0; gi < 15; gi++) begin : g_mag
            assign head_conv[gi] = head_word[gi];
        end
    endgenerate

`ifdef DAC_FEED_SIGNED_EN
    assign head_conv[15] = ~head_word[15];
`else
    assign head_conv[15] = head_word[15];
`endif

    // Sample storage is left unreset. Resetting the pointers is enough to discard
    // the FIFO contents.
    always_ff @(posedge CLK_50) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= S_DATA;
        end
    end

    always_ff @(posedge CLK_50) begin
        if (!RESET_N) begin
            rd_ptr_reg       <= '0;
            wr_ptr_reg       <= '0;
            fill_reg         <= '0;
            s_ready_reg      <= 1'b1;
            div_cnt_reg      <= '0;
            data16_reg       <= MIDSCALE;
            underrun_reg     <= 1'b0;
            underrun_cnt_reg <= '0;
        end else begin
            div_cnt_reg  <= tick ? 16'd0 : div_cnt_reg + 16'd1;
            fill_reg     <= fill_next;
            s_ready_reg  <= (fill_next != FULL_LEVEL);
            underrun_reg <= tick && empty;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
                data16_reg <= head_conv;
            end
            if (tick && empty && (underrun_cnt_reg != 16'hFFFF)) begin
                underrun_cnt_reg <= underrun_cnt_reg + 16'd1;
            end
        end
    end

    // The LOAD pulse starts on every tick, including underrun ticks. The
    // serializer then re-sends the held sample.
    always_ff @(posedge CLK_50) begin
        if (!RESET_N) begin
            state_reg     <= IDLE;
            width_cnt_reg <= '0;
            load_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (tick) begin
                        state_reg     <= PULSE;
                        width_cnt_reg <= WIDTH_INIT;
                        load_reg      <= 1'b1;
                    end
                end
                PULSE: begin
                    if (width_cnt_reg == '0) begin
                        state_reg <= IDLE;
                        load_reg  <= 1'b0;
                    end else begin
                        width_cnt_reg <= width_cnt_reg - 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    load_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign S_READY      = s_ready_reg;
    assign DATA16       = data16_reg;
    assign LOAD         = load_reg;
    assign UNDERRUN     = underrun_reg;
    assign UNDERRUN_CNT = underrun_cnt_reg;
    assign FILL         = fill_reg;

endmodule

// File: tb/tb_dac_sample_feeder.sv
module tb_dac_sample_feeder;

    localparam int DIV        = 700;
    localparam int DEPTH_LOG2 = 2;
    localparam int LOAD_W     = 4;

    logic                CLK_50;
    logic                RESET_N;
    logic [15:0]         S_DATA;
    logic                S_VALID;
    logic                S_READY;
    logic [15:0]         DATA16;
    logic                LOAD;
    logic                UNDERRUN;
    logic [15:0]         UNDERRUN_CNT;
    logic [DEPTH_LOG2:0] FILL;

    int          total;
    int          bad;
    int          cyc;
    logic [15:0] exp_q[$];
    logic [15:0] exp_last;
    logic [15:0] exp_ucnt;
    logic        load_prev;

    dac_sample_feeder #(
        .DIV        (DIV),
        .DEPTH_LOG2 (DEPTH_LOG2),
        .LOAD_W     (LOAD_W)
    ) dut (
        .CLK_50       (CLK_50),
        .RESET_N      (RESET_N),
        .S_DATA       (S_DATA),
        .S_VALID      (S_VALID),
        .S_READY      (S_READY),
        .DATA16       (DATA16),
        .LOAD         (LOAD),
        .UNDERRUN     (UNDERRUN),
        .UNDERRUN_CNT (UNDERRUN_CNT),
        .FILL         (FILL)
    );

    initial CLK_50 = 1'b0;
    always #5 CLK_50 = ~CLK_50;

    function automatic logic [15:0] conv(input logic [15:0] v);
`ifdef DAC_FEED_SIGNED_EN
        return {~v[15], v[14:0]};
`else
        return v;
`endif
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK_50);
            #1;
            cyc++;
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step(1);
    endtask

    // Scoreboard: each LOAD rising edge marks one tick result.
    // The result is either the next queued sample or an underrun.
    initial load_prev = 1'b0;
    always begin
        @(posedge CLK_50);
        #2;
        if (LOAD === 1'b1 && load_prev === 1'b0) begin
            total++;
            if ((cyc % DIV) != 0) begin
                bad++;
                $display("FAIL load_phase: LOAD rose at cycle %0d, required a multiple of %0d", cyc, DIV);
            end
            if (exp_q.size() > 0) begin
                exp_last = exp_q.pop_front();
                total++;
                if (DATA16 !== exp_last) begin
                    bad++;
                    $display("FAIL pop_data: cycle %0d DATA16=%h required %h", cyc, DATA16, exp_last);
                end
                total++;
                if (UNDERRUN !== 1'b0) begin
                    bad++;
                    $display("FAIL pop_underrun: cycle %0d UNDERRUN=%b required 0", cyc, UNDERRUN);
                end
            end else begin
                if (exp_ucnt != 16'hFFFF) exp_ucnt = exp_ucnt + 16'd1;
                total++;
                if (UNDERRUN !== 1'b1) begin
                    bad++;
                    $display("FAIL underrun_pulse: cycle %0d UNDERRUN=%b required 1", cyc, UNDERRUN);
                end
                total++;
                if (DATA16 !== exp_last) begin
                    bad++;
                    $display("FAIL underrun_hold: cycle %0d DATA16=%h required %h", cyc, DATA16, exp_last);
                end
            end
            total++;
            if (UNDERRUN_CNT !== exp_ucnt) begin
                bad++;
                $display("FAIL underrun_cnt: cycle %0d UNDERRUN_CNT=%h required %h", cyc, UNDERRUN_CNT, exp_ucnt);
            end
            $display("tick cycle=%0d DATA16=%h UNDERRUN=%b UNDERRUN_CNT=%h", cyc, DATA16, UNDERRUN, UNDERRUN_CNT);
        end
        load_prev = LOAD;
    end

    task automatic test_reset;
        RESET_N  = 1'b0;
        S_VALID  = 1'b0;
        S_DATA   = 16'h0000;
        exp_last = 16'h8000;
        exp_ucnt = 16'h0000;
        repeat (3) @(posedge CLK_50);
        #1;
        RESET_N = 1'b1;
        cyc = 0;
        total++; if (FILL !== 3'd0) begin bad++; $display("FAIL rst_fill: FILL=%0d required 0", FILL); end
        total++; if (S_READY !== 1'b1) begin bad++; $display("FAIL rst_ready: S_READY=%b required 1", S_READY); end
        total++; if (DATA16 !== 16'h8000) begin bad++; $display("FAIL rst_data: DATA16=%h required 8000", DATA16); end
        total++; if (LOAD !== 1'b0) begin bad++; $display("FAIL rst_load: LOAD=%b required 0", LOAD); end
        total++; if (UNDERRUN !== 1'b0) begin bad++; $display("FAIL rst_underrun: UNDERRUN=%b required 0", UNDERRUN); end
        total++; if (UNDERRUN_CNT !== 16'h0) begin bad++; $display("FAIL rst_ucnt: UNDERRUN_CNT=%h required 0", UNDERRUN_CNT); end
        $display("reset released: FILL=%0d S_READY=%b DATA16=%h", FILL, S_READY, DATA16);
    endtask

    task automatic test_first_tick;
        logic exp_load;
        logic exp_und;
        while (cyc < 705) begin
            step(1);
            exp_load = (cyc >= 700) && (cyc <= 703);
            exp_und  = (cyc == 700);
            total++;
            if (LOAD !== exp_load) begin
                bad++;
                $display("FAIL first_load: cycle %0d LOAD=%b required %b", cyc, LOAD, exp_load);
            end
            total++;
            if (UNDERRUN !== exp_und) begin
                bad++;
                $display("FAIL first_underrun: cycle %0d UNDERRUN=%b required %b", cyc, UNDERRUN, exp_und);
            end
            if (cyc == 700) begin
                total++;
                if (UNDERRUN_CNT !== 16'd1) begin bad++; $display("FAIL first_ucnt: UNDERRUN_CNT=%h required 0001", UNDERRUN_CNT); end
                total++;
                if (DATA16 !== 16'h8000) begin bad++; $display("FAIL first_data: DATA16=%h required 8000", DATA16); end
            end
        end
        $display("first tick window checked through cycle %0d", cyc);
    endtask

    task automatic test_fill_full;
        logic [15:0] vals [4];
        vals[0] = 16'h1234; vals[1] = 16'h5678; vals[2] = 16'h9ABC; vals[3] = 16'hDEF0;
        wait_until(710);
        for (int i = 0; i < 4; i++) begin
            S_DATA  = vals[i];
            S_VALID = 1'b1;
            total++;
            if (S_READY !== 1'b1) begin
                bad++;
                $display("FAIL push_ready: push %0d S_READY=%b required 1", i, S_READY);
            end
            exp_q.push_back(conv(vals[i]));
            step(1);
            $display("push data=%h cycle=%0d", vals[i], cyc);
        end
        total++; if (FILL !== 3'd4) begin bad++; $display("FAIL full_fill: FILL=%0d required 4", FILL); end
        total++; if (S_READY !== 1'b0) begin bad++; $display("FAIL full_ready: S_READY=%b required 0", S_READY); end
        S_DATA  = 16'h1111;
        S_VALID = 1'b1;
        step(1);
        total++; if (FILL !== 3'd4) begin bad++; $display("FAIL fifth_push: FILL=%0d required 4", FILL); end
        wait_until(1399);
        total++; if (FILL !== 3'd4) begin bad++; $display("FAIL pre_tick_fill: FILL=%0d required 4", FILL); end
        step(1);
        total++; if (FILL !== 3'd3) begin bad++; $display("FAIL tick_full_fill: FILL=%0d required 3", FILL); end
        total++; if (S_READY !== 1'b1) begin bad++; $display("FAIL tick_full_ready: S_READY=%b required 1", S_READY); end
        S_VALID = 1'b0;
        wait_until(3504);
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL drain_queue: %0d samples not emitted, required 0", exp_q.size()); end
        total++; if (FILL !== 3'd0) begin bad++; $display("FAIL drain_fill: FILL=%0d required 0", FILL); end
        $display("full FIFO drained at cycle %0d", cyc);
    endtask

    task automatic test_data_conv;
        wait_until(3510);
        S_VALID = 1'b1;
        S_DATA  = 16'hFFFF;
        exp_q.push_back(conv(16'hFFFF));
        step(1);
        S_DATA  = 16'h0001;
        exp_q.push_back(conv(16'h0001));
        step(1);
        S_VALID = 1'b0;
        wait_until(4200);
        total++; if (DATA16 !== conv(16'hFFFF)) begin bad++; $display("FAIL conv_ffff: DATA16=%h required %h", DATA16, conv(16'hFFFF)); end
        wait_until(4900);
        total++; if (DATA16 !== conv(16'h0001)) begin bad++; $display("FAIL conv_0001: DATA16=%h required %h", DATA16, conv(16'h0001)); end
        $display("conversion samples emitted, last DATA16=%h", DATA16);
    endtask

    task automatic test_saturation;
        wait_until(4910);
        force dut.underrun_cnt_reg = 16'hFFFE;
        exp_ucnt = 16'hFFFE;
        step(1);
        release dut.underrun_cnt_reg;
        total++; if (UNDERRUN_CNT !== 16'hFFFE) begin bad++; $display("FAIL sat_preload: UNDERRUN_CNT=%h required fffe", UNDERRUN_CNT); end
        wait_until(6301);
        total++; if (UNDERRUN_CNT !== 16'hFFFF) begin bad++; $display("FAIL sat_hold: UNDERRUN_CNT=%h required ffff", UNDERRUN_CNT); end
        $display("saturation UNDERRUN_CNT=%h cycle=%0d", UNDERRUN_CNT, cyc);
    endtask

    task automatic test_reset_mid;
        wait_until(6310);
        S_VALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            S_DATA = 16'hA001 + 16'(i);
            exp_q.push_back(conv(S_DATA));
            step(1);
        end
        S_VALID = 1'b0;
        wait_until(7001);
        total++; if (LOAD !== 1'b1) begin bad++; $display("FAIL mid_load_before: LOAD=%b required 1", LOAD); end
        total++; if (FILL !== 3'd2) begin bad++; $display("FAIL mid_fill_before: FILL=%0d required 2", FILL); end
        RESET_N = 1'b0;
        exp_q.delete();
        exp_last = 16'h8000;
        exp_ucnt = 16'h0000;
        step(1);
        RESET_N = 1'b1;
        cyc = 0;
        total++; if (LOAD !== 1'b0) begin bad++; $display("FAIL mid_load: LOAD=%b required 0", LOAD); end
        total++; if (FILL !== 3'd0) begin bad++; $display("FAIL mid_fill: FILL=%0d required 0", FILL); end
        total++; if (DATA16 !== 16'h8000) begin bad++; $display("FAIL mid_data: DATA16=%h required 8000", DATA16); end
        total++; if (UNDERRUN_CNT !== 16'h0) begin bad++; $display("FAIL mid_ucnt: UNDERRUN_CNT=%h required 0", UNDERRUN_CNT); end
        wait_until(699);
        total++; if (LOAD !== 1'b0) begin bad++; $display("FAIL restart_699: LOAD=%b required 0", LOAD); end
        step(1);
        total++; if (LOAD !== 1'b1) begin bad++; $display("FAIL restart_700: LOAD=%b required 1", LOAD); end
        total++; if (UNDERRUN !== 1'b1) begin bad++; $display("FAIL restart_underrun: UNDERRUN=%b required 1", UNDERRUN); end
        step(2);
        $display("mid-pulse reset recovered, divider restarted");
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        test_reset;
        test_first_tick;
        test_fill_full;
        test_data_conv;
        test_saturation;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dac_sample_feeder.md
# dac_sample_feeder

Paces 16-bit audio samples into the 24-bit SPI DAC serializer at a fixed sample rate. Samples from the FM/audio datapath enter a small FIFO through a valid/ready handshake. A programmable divider on CLK_50 generates the sample tick. On each tick the block pops one sample, drives it on DATA16 and pulses LOAD so the serializer starts a frame. It sits directly upstream of the DAC serializer, and its DATA16/LOAD outputs connect one-to-one to that block's inputs.

## Interface
- DIV, 1250: CLK_50 cycles per sample tick (1250 gives 40 kHz). Legal range is 640 to 65535, so a full serializer frame always completes between ticks.
- DEPTH_LOG2, 4: FIFO depth is 2^DEPTH_LOG2 entries. Legal range 1..8.
- LOAD_W, 4: LOAD pulse width in CLK_50 cycles. Minimum 2, because the serializer samples LOAD on its half-rate clock.
- CLK_50  in  1  system clock; all logic is on its rising edge.
- RESET_N  in  1  synchronous, active-low reset.
- S_DATA  in  16  upstream sample.
- S_VALID  in  1  S_DATA is valid.
- S_READY  out  1  FIFO can accept a sample.
- DATA16  out  16  sample presented to the serializer.
- LOAD  out  1  frame-start request to the serializer.
- UNDERRUN  out  1  one-cycle pulse when a tick finds the FIFO empty.
- UNDERRUN_CNT  out  16  saturating underrun count.
- FILL  out  DEPTH_LOG2+1  current FIFO occupancy.

## Operation
- Reset applies when RESET_N is low at a rising edge, in any state. A reset mid-operation discards FIFO contents and any LOAD pulse in progress. Values after reset:
  - FILL=0, S_READY=1
  - DATA16=16'h8000 (midscale), LOAD=0
  - UNDERRUN=0, UNDERRUN_CNT=0
  - divider count=0, state=IDLE
- FIFO:
  - Circular buffer with read and write pointers of width DEPTH_LOG2; pointers wrap modulo depth.
  - S_READY = (FILL != 2^DEPTH_LOG2).
  - A push occurs when S_VALID && S_READY.
- Divider:
  - Counts 0..DIV-1 and wraps.
  - tick = (count == DIV-1).
  - Runs continuously and is independent of FIFO state.
- On tick, FIFO non-empty: pop the head entry. DATA16 takes the head value (converted per Configuration) on the next edge.
- On tick, FIFO empty: DATA16 holds its previous value. UNDERRUN pulses. UNDERRUN_CNT increments and saturates at 16'hFFFF.
- Push and pop in the same cycle: both happen and FILL is unchanged.
- Push into an empty FIFO on a tick cycle: no bypass. The tick counts as an underrun and the new sample is kept for the next tick.
- Push when full: not accepted, even if a pop occurs in the same cycle, because S_READY was low.
- State machine:
  - IDLE: on tick, go to PULSE and load the width counter with LOAD_W-1.
  - PULSE: LOAD=1. Decrement the width counter each cycle. At 0, go to IDLE.
- An underrun still produces a LOAD pulse, so the serializer re-sends the held sample and keeps the DAC frame rate constant.
- DATA16 changes only in the cycle after a tick and is stable for the remaining DIV-1 cycles. This covers the serializer capturing DATA16 at frame start.

## Timing
- Ticks occur at cycles where count == DIV-1. The first tick is DIV-1 cycles after the first non-reset edge.
- Tick at cycle t:
  - DATA16, FILL and UNDERRUN are updated at t+1.
  - LOAD is high for cycles t+1 .. t+LOAD_W.
- S_READY and FILL are registered and reflect pushes and pops one cycle later.
- Push latency: a sample accepted at cycle p, with the FIFO otherwise empty, appears on DATA16 at the first tick t ≥ p+1, plus 1 cycle.
- LOAD period is exactly DIV cycles. Since LOAD_W < DIV, pulses never overlap.

## Configuration
- DAC_FEED_SIGNED_EN:
  - Defined: S_DATA is two's complement, and DATA16 = {~head[15], head[14:0]} (offset binary for the DAC).
  - Undefined: DATA16 = head, passed unchanged.
- The reset value of DATA16 is 16'h8000 in both cases.

## Test plan
Bench parameters: DIV=700, LOAD_W=4, DEPTH_LOG2=2, DAC_FEED_SIGNED_EN undefined unless noted.
- Reset released, no input:
  - First tick at cycle 699. LOAD is high for cycles 700-703.
  - UNDERRUN pulses at cycle 700. UNDERRUN_CNT=1 and DATA16=16'h8000.
- Push 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0:
  - FILL reaches 4 and S_READY drops.
  - A fifth S_VALID is not accepted.
  - The next four ticks emit the samples in order with one LOAD pulse each.
- With FILL=4, hold S_VALID on a tick cycle:
  - The pop happens, the push does not.
  - At the next cycle S_READY=1 and FILL=3.
- DAC_FEED_SIGNED_EN defined, push 16'hFFFF then 16'h0001:
  - DATA16 = 16'h7FFF, then 16'h8001.
- Pre-load UNDERRUN_CNT to 16'hFFFE via 2 underruns with forced state, or run 65537 empty ticks in a long run:
  - The count stops at 16'hFFFF.
- Assert RESET_N low during the LOAD pulse with FILL=2:
  - Next cycle LOAD=0, FILL=0, DATA16=16'h8000 and the divider restarts at 0.
